// File: rtl/rv_pkg.sv
// Shared RV32I core constants and types: architectural widths, register index
// and data word types, and the hard-wired zero register index.
package rv_pkg;
    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]       xword_t;

    localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/rv_regbank_if.sv
// Bundle of the writeback, issue and flush inputs and the parallel register and
// busy views exported by the register bank.
interface rv_regbank_if
    import rv_pkg::*;
#(
    parameter int DATA_W   = XLEN,
    parameter int NUM_REGS = NREGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
);
    logic                wb_en;
    logic [ADDR_W-1:0]   wb_addr;
    logic [DATA_W-1:0]   wb_data;
    logic                iss_en;
    logic [ADDR_W-1:0]   iss_rd;
    logic                flush;
    logic [DATA_W-1:0]   regs_o [NUM_REGS];
    logic [NUM_REGS-1:0] busy_o;
    logic                any_busy_o;

    modport master (
        output wb_en, wb_addr, wb_data, iss_en, iss_rd, flush,
        input  regs_o, busy_o, any_busy_o
    );

    modport slave (
        input  wb_en, wb_addr, wb_data, iss_en, iss_rd, flush,
        output regs_o, busy_o, any_busy_o
    );
endinterface

// File: rtl/rv_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, updated with
// flush > issue > writeback priority. Bit 0 (x0) never becomes busy.
module rv_scoreboard
    import rv_pkg::*;
#(
    parameter int NUM_REGS = NREGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                iss_en,
    input  logic [ADDR_W-1:0]   iss_rd,
    input  logic                wb_en,
    input  logic [ADDR_W-1:0]   wb_addr,
    output logic [NUM_REGS-1:0] busy
);
    assign busy[REG_ZERO] = 1'b0;

    // Issue beats writeback on the same index: the issuing instruction is the younger producer.
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_busy
        logic busy_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                busy_reg <= 1'b0;
            end else if (flush) begin
                busy_reg <= 1'b0;
            end else if (iss_en && iss_rd == ADDR_W'(gi)) begin
                busy_reg <= 1'b1;
            end else if (wb_en && wb_addr == ADDR_W'(gi)) begin
                busy_reg <= 1'b0;
            end
        end

        assign busy[gi] = busy_reg;
    end
endmodule

// File: rtl/rv_regbank.sv
// Architectural register file x0..x(NUM_REGS-1) exposed in parallel, with x0 tied
// to zero and a pending-write scoreboard for RAW hazard detection at issue.
module rv_regbank
    import rv_pkg::*;
#(
    parameter int DATA_W   = XLEN,
    parameter int NUM_REGS = NREGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic         clk,
    input  logic         rst_n,
    rv_regbank_if.slave  bus
);
    logic [NUM_REGS-1:0] busy;

    assign bus.regs_o[REG_ZERO] = '0;

    // Each register is its own flop bank so the parallel outputs need no read mux;
    // index 0 is never matched here, which discards writes to x0.
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
        logic [DATA_W-1:0] data_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_reg <= '0;
            end else if (bus.wb_en && bus.wb_addr == ADDR_W'(gi)) begin
                data_reg <= bus.wb_data;
            end
        end

        assign bus.regs_o[gi] = data_reg;
    end

    rv_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (bus.flush),
        .iss_en  (bus.iss_en),
        .iss_rd  (bus.iss_rd),
        .wb_en   (bus.wb_en),
        .wb_addr (bus.wb_addr),
        .busy    (busy)
    );

    assign bus.busy_o     = busy;
    assign bus.any_busy_o = |busy;
endmodule

// File: tb/tb_rv_regbank.sv
// Directed and randomized bench for rv_regbank against an array-based model of the
// register file and its pending-write marks.
module tb_rv_regbank;
    logic clk;
    logic rst_n;

    rv_regbank_if bus ();

    rv_regbank dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mregs [32];
    logic [31:0] mbusy;
    int          n_pass;
    int          n_total;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        mbusy = '0;
    endtask

    task automatic chk(string tag, logic [31:0] observed, logic [31:0] expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    task automatic check_all(string tag);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("%s regs_o[%0d]", tag, i), bus.regs_o[i], mregs[i]);
        end
        chk($sformatf("%s busy_o", tag), bus.busy_o, mbusy);
        chk($sformatf("%s any_busy_o", tag), {31'd0, bus.any_busy_o}, {31'd0, mbusy != 0});
    endtask

    // One clock of stimulus; called at a falling edge, returns at the next falling edge.
    task automatic step(string tag, logic we, logic [4:0] wa, logic [31:0] wd,
                        logic ie, logic [4:0] ir, logic fl);
        bus.wb_en   = we;
        bus.wb_addr = wa;
        bus.wb_data = wd;
        bus.iss_en  = ie;
        bus.iss_rd  = ir;
        bus.flush   = fl;
        @(posedge clk);
        if (we && wa != 0) mregs[wa] = wd;
        if (fl) begin
            mbusy = '0;
        end else begin
            if (we && wa != 0) mbusy[wa] = 1'b0;
            if (ie && ir != 0) mbusy[ir] = 1'b1;
        end
        @(negedge clk);
        $display("%s: wb=%0b x%0d=%h iss=%0b rd=%0d flush=%0b busy=%h",
                 tag, we, wa, wd, ie, ir, fl, bus.busy_o);
        check_all(tag);
    endtask

    task automatic idle(string tag);
        step(tag, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n       = 1'b0;
        bus.wb_en   = 1'b0;
        bus.wb_addr = '0;
        bus.wb_data = '0;
        bus.iss_en  = 1'b0;
        bus.iss_rd  = '0;
        bus.flush   = 1'b0;
        model_reset();

        // Reset held across a clock edge with a write pending: nothing may land.
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd6;
        bus.wb_data = 32'hCAFE0006;
        repeat (2) @(negedge clk);
        check_all("in_reset");
        bus.wb_en = 1'b0;
        rst_n     = 1'b1;

        // Write x5 then attempt x0.
        step("wr_x5", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
        chk("x5_value", bus.regs_o[5], 32'hDEADBEEF);
        step("wr_x0", 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 1'b0);
        chk("x0_zero", bus.regs_o[0], 32'h0);
        chk("x5_hold", bus.regs_o[5], 32'hDEADBEEF);

        // Back-to-back writes to x31.
        step("wr_x31_a", 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0, 1'b0);
        chk("x31_first", bus.regs_o[31], 32'hFFFFFFFF);
        step("wr_x31_b", 1'b1, 5'd31, 32'h00000001, 1'b0, 5'd0, 1'b0);
        chk("x31_second", bus.regs_o[31], 32'h00000001);

        // Issue rd=7, writeback three cycles later.
        step("iss_x7", 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0);
        chk("x7_busy_c1", {31'd0, bus.busy_o[7]}, 32'd1);
        idle("wait_x7_a");
        chk("x7_busy_c2", {31'd0, bus.busy_o[7]}, 32'd1);
        idle("wait_x7_b");
        chk("x7_busy_c3", {31'd0, bus.any_busy_o}, 32'd1);
        step("wb_x7", 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0);
        chk("x7_clear", {31'd0, bus.busy_o[7]}, 32'd0);
        chk("x7_any_clear", {31'd0, bus.any_busy_o}, 32'd0);
        chk("x7_value", bus.regs_o[7], 32'hA5A5A5A5);

        // Issue to rd=0 marks nothing.
        step("iss_x0", 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0);
        chk("x0_never_busy", {31'd0, bus.any_busy_o}, 32'd0);

        // Simultaneous issue and writeback on a busy register.
        step("iss_x9", 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0);
        step("iss_wb_x9", 1'b1, 5'd9, 32'h99990009, 1'b1, 5'd9, 1'b0);
        chk("x9_still_busy", {31'd0, bus.busy_o[9]}, 32'd1);
        chk("x9_value", bus.regs_o[9], 32'h99990009);
        step("wb_x9", 1'b1, 5'd9, 32'h0000AAAA, 1'b0, 5'd0, 1'b0);
        chk("x9_clear", {31'd0, bus.busy_o[9]}, 32'd0);

        // Flush wins over a same-cycle issue and writeback; data still commits.
        step("iss_x3", 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0);
        step("iss_x4", 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0);
        step("flush", 1'b1, 5'd3, 32'h00000055, 1'b1, 5'd12, 1'b1);
        chk("flush_busy", bus.busy_o, 32'd0);
        chk("flush_x3", bus.regs_o[3], 32'h00000055);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            step($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 $urandom_range(0, 15) == 0);
        end

        // Asynchronous reset mid-run, checked before the next rising edge.
        step("pre_rst_iss", 1'b1, 5'd20, 32'h20202020, 1'b1, 5'd21, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        check_all("rst_held");
        step("post_rst_wr", 1'b1, 5'd1, 32'h00000011, 1'b1, 5'd2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
